// File: rtl/parity_frame_seq.sv
// parity_frame_seq
//   Takes parallel words on a valid/ready handshake and shifts each one out
//   LSB first, one bit per clock, followed by a single parity trailer bit.
//   The frame markers feed the downstream serial parity logic. The parity of
//   each completed frame is also reported in parallel.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     in_data    word to transmit, captured on handshake
//     in_valid   in_data valid
//     in_ready   a word can be accepted this cycle (comb, from state only)
//     ser_x      serial bit: payload bits, then the parity trailer
//     ser_en     ser_x carries a bit this cycle
//     ser_sof    ser_x is payload bit 0 of a frame
//     ser_pbit   ser_x is the parity trailer
//     par_bit    parity of the last completed frame, held until the next one
//     par_valid  one-cycle pulse when par_bit is updated
//     busy       sequencer is not idle
module parity_frame_seq #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_x,
  output logic              ser_en,
  output logic              ser_sof,
  output logic              ser_pbit,
  output logic              par_bit,
  output logic              par_valid,
  output logic              busy
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, TRAIL} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DATA_W-1:0] sreg, sreg_n;
  logic              acc, acc_n;
  logic              take;

  // Serial outputs for the coming cycle, derived from the next-state values
  // so the registered outputs line up with the state they describe.
  logic              x_n, en_n, sof_n, pbit_n;

  assign in_ready = (state == IDLE) || (state == TRAIL);
  assign take     = in_valid && in_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    acc_n   = acc;
    case (state)
      IDLE: begin
        if (take) begin
          state_n = SHIFT;
          sreg_n  = in_data;
          cnt_n   = '0;
          acc_n   = 1'b0;
        end
      end
      SHIFT: begin
        acc_n  = acc ^ sreg[0];
        sreg_n = sreg >> 1;
        if (cnt == LAST) state_n = TRAIL;
        else             cnt_n   = cnt + 1'b1;
      end
      TRAIL: begin
        // A handshake here restarts immediately: no gap cycle between frames.
        if (take) begin
          state_n = SHIFT;
          sreg_n  = in_data;
          cnt_n   = '0;
          acc_n   = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    x_n    = 1'b0;
    en_n   = 1'b0;
    sof_n  = 1'b0;
    pbit_n = 1'b0;
    case (state_n)
      SHIFT: begin
        x_n   = sreg_n[0];
        en_n  = 1'b1;
        sof_n = (cnt_n == '0);
      end
      TRAIL: begin
        x_n    = acc_n ^ PARITY_ODD;
        en_n   = 1'b1;
        pbit_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= '0;
      acc       <= 1'b0;
      ser_x     <= 1'b0;
      ser_en    <= 1'b0;
      ser_sof   <= 1'b0;
      ser_pbit  <= 1'b0;
      busy      <= 1'b0;
      par_bit   <= 1'b0;
      par_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sreg      <= sreg_n;
      acc       <= acc_n;
      ser_x     <= x_n;
      ser_en    <= en_n;
      ser_sof   <= sof_n;
      ser_pbit  <= pbit_n;
      busy      <= (state_n != IDLE);
      // TRAIL always lasts exactly one cycle, so being in it means leaving it.
      par_valid <= (state == TRAIL);
      if (state == TRAIL) par_bit <= acc ^ PARITY_ODD;
    end
  end

endmodule
